// File: rtl/sysx_pkg.sv
// Shared constants for the SYSX bus master: register map, CONFIG/STATUS
// bit positions and the transfer engine state encoding.
package sysx_pkg;

    localparam logic [2:0] REG_CONFIG  = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_TXDATA  = 3'd2;
    localparam logic [2:0] REG_RXDATA  = 3'd3;
    localparam logic [2:0] REG_TXCOUNT = 3'd4;
    localparam logic [2:0] REG_RXCOUNT = 3'd5;

    localparam logic [31:0] BAD_REG_VALUE = 32'h0BADC0DE;

    localparam int CFG_DIV_LSB  = 0;
    localparam int CFG_DIV_W    = 4;
    localparam int CFG_CHAN_LSB = 4;
    localparam int CFG_CHAN_W   = 3;
    localparam int CFG_START    = 7;
    localparam int CFG_IE_RX    = 8;
    localparam int CFG_IE_BUS   = 9;
    localparam int CFG_IE_DONE  = 10;

    localparam int ST_BUSY     = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_DONE     = 5;
    localparam int ST_BUS_IRQ  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEGIN,
        S_LOWLOW,
        S_LOW,
        S_HIGH,
        S_HIGHHIGH,
        S_END
    } eng_state_e;

endpackage

// File: rtl/sysx_fifo.sv
// Synchronous FIFO used for both the TX and RX byte queues.
// Pushes while full and pops while empty are ignored; the caller flags overflow.
module sysx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are exactly AW bits wide, so wrap is free for power-of-two depths.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/sysx_master_v2.sv
// SYSX serial bus master: register front end, TX/RX FIFOs and a byte
// transfer engine producing select, bus clock and MOSI, sampling MISO.
module sysx_master_v2
    import sysx_pkg::*;
#(
    parameter int BUS_W      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CHANNELS   = 4
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iEnable,
    input  logic                iWrite,
    input  logic [2:0]          iAddress,
    inout  wire  [31:0]         bData,
    input  logic [BUS_W-1:0]    iBusMISO,
    output logic [BUS_W-1:0]    oBusMOSI,
    output logic                oBusClock,
    output logic [CHANNELS-1:0] oBusSelect,
    input  logic                iBusInterrupt,
    output logic                oInterrupt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    eng_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       div_q, div_d;
    logic [2:0]       chan_q, chan_d;
    logic [2:0]       sel_chan_q, sel_chan_d;
    logic             start_q, start_d;
    logic             ie_rx_q, ie_rx_d;
    logic             ie_bus_q, ie_bus_d;
    logic             ie_done_q, ie_done_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic             rx_ovf_q, rx_ovf_d;
    logic             done_q, done_d;
    logic             irq_q, irq_d;
    logic [BUS_W-1:0] mosi_q, mosi_d;
    logic [BUS_W-1:0] miso_q, miso_d;

    logic             cfg_wr, tx_wr, rx_rd, busy;
    logic             tx_pop, rx_push, start_clr, done_set;
    logic [BUS_W-1:0] tx_rdata, rx_rdata;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]    tx_count, rx_count;
    logic [31:0]      rdata;
    logic             unused_bdata;

    assign cfg_wr = iEnable & iWrite & (iAddress == REG_CONFIG);
    assign tx_wr  = iEnable & iWrite & (iAddress == REG_TXDATA);
    assign rx_rd  = iEnable & ~iWrite & (iAddress == REG_RXDATA);
    assign busy   = (state_q != S_IDLE);
    assign unused_bdata = ^bData[31:11];

    sysx_fifo #(.WIDTH(BUS_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(iClock), .rst(iReset), .push(tx_wr), .pop(tx_pop),
        .wdata(bData[BUS_W-1:0]), .rdata(tx_rdata),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sysx_fifo #(.WIDTH(BUS_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(iClock), .rst(iReset), .push(rx_push), .pop(rx_rd),
        .wdata(miso_q), .rdata(rx_rdata),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Engine: every non-idle state lasts DIV+1 clocks, cnt_q counts within it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_chan_d = sel_chan_q;
        mosi_d     = mosi_q;
        miso_d     = miso_q;
        tx_pop     = 1'b0;
        start_clr  = 1'b0;
        done_set   = 1'b0;
        if (state_q == S_IDLE) begin
            if (start_q && !tx_empty) begin
                state_d    = S_BEGIN;
                cnt_d      = '0;
                sel_chan_d = chan_q;
                start_clr  = 1'b1;
            end
        end else if (cnt_q != div_q) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = '0;
            case (state_q)
                S_BEGIN: begin
                    state_d = S_LOWLOW;
                    tx_pop  = 1'b1;
                    mosi_d  = tx_rdata;
                end
                S_LOWLOW:   state_d = S_LOW;
                S_LOW:      state_d = S_HIGH;
                S_HIGH:     state_d = S_HIGHHIGH;
                S_HIGHHIGH: begin
                    state_d = S_END;
                    miso_d  = iBusMISO;
                end
                S_END: begin
                    if (!tx_empty) begin
                        state_d = S_LOWLOW;
                        tx_pop  = 1'b1;
                        mosi_d  = tx_rdata;
                    end else begin
                        state_d  = S_IDLE;
                        done_set = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rx_push = (state_q == S_END) && (cnt_q == '0);

    // DIV/CHAN are frozen during a transfer; IE and the sticky clear are not.
    always_comb begin
        div_d     = div_q;
        chan_d    = chan_q;
        start_d   = start_q & ~start_clr;
        ie_rx_d   = ie_rx_q;
        ie_bus_d  = ie_bus_q;
        ie_done_d = ie_done_q;
        if (cfg_wr) begin
            if (!busy) begin
                div_d  = bData[CFG_DIV_LSB +: CFG_DIV_W];
                chan_d = bData[CFG_CHAN_LSB +: CFG_CHAN_W];
            end
            start_d   = bData[CFG_START];
            ie_rx_d   = bData[CFG_IE_RX];
            ie_bus_d  = bData[CFG_IE_BUS];
            ie_done_d = bData[CFG_IE_DONE];
        end
        tx_ovf_d = (tx_ovf_q & ~cfg_wr) | (tx_wr & tx_full);
        rx_ovf_d = (rx_ovf_q & ~cfg_wr) | (rx_push & rx_full);
        done_d   = (done_q & ~cfg_wr) | done_set;
        irq_d    = (ie_rx_q & ~rx_empty) | (ie_bus_q & iBusInterrupt) | (ie_done_q & done_q);
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            chan_q     <= '0;
            sel_chan_q <= '0;
            start_q    <= 1'b0;
            ie_rx_q    <= 1'b0;
            ie_bus_q   <= 1'b0;
            ie_done_q  <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            mosi_q     <= '0;
            miso_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            chan_q     <= chan_d;
            sel_chan_q <= sel_chan_d;
            start_q    <= start_d;
            ie_rx_q    <= ie_rx_d;
            ie_bus_q   <= ie_bus_d;
            ie_done_q  <= ie_done_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
            mosi_q     <= mosi_d;
            miso_q     <= miso_d;
        end
    end

    // Out-of-range channel numbers simply match no select line.
    always_comb begin
        oBusSelect = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            oBusSelect[i] = busy && (32'(sel_chan_q) == i);
        end
    end

    assign oBusClock  = (state_q == S_HIGH) || (state_q == S_HIGHHIGH);
    assign oBusMOSI   = mosi_q;
    assign oInterrupt = irq_q;

    always_comb begin
        rdata = '0;
        case (iAddress)
            REG_CONFIG: begin
                rdata[CFG_DIV_LSB +: CFG_DIV_W]   = div_q;
                rdata[CFG_CHAN_LSB +: CFG_CHAN_W] = chan_q;
                rdata[CFG_START]                  = start_q;
                rdata[CFG_IE_RX]                  = ie_rx_q;
                rdata[CFG_IE_BUS]                 = ie_bus_q;
                rdata[CFG_IE_DONE]                = ie_done_q;
            end
            REG_STATUS: begin
                rdata[ST_BUSY]     = busy;
                rdata[ST_TX_FULL]  = tx_full;
                rdata[ST_RX_EMPTY] = rx_empty;
                rdata[ST_TX_OVF]   = tx_ovf_q;
                rdata[ST_RX_OVF]   = rx_ovf_q;
                rdata[ST_DONE]     = done_q;
                rdata[ST_BUS_IRQ]  = iBusInterrupt;
            end
            REG_TXDATA:  rdata = '0;
            REG_RXDATA:  rdata = rx_empty ? 32'h0 : 32'(rx_rdata);
            REG_TXCOUNT: rdata = 32'(tx_count);
            REG_RXCOUNT: rdata = 32'(rx_count);
            default:     rdata = BAD_REG_VALUE;
        endcase
    end

    assign bData = (iEnable && !iWrite) ? rdata : 32'bz;

endmodule

// File: tb/tb_sysx_master_v2.sv
// Scoreboard bench for sysx_master_v2: queue-based reference model, register
// read monitor and bus-side monitor for MOSI, select and bus clock timing.
module tb_sysx_master_v2;

    logic        iClock = 1'b0;
    logic        iReset, iEnable, iWrite, iBusInterrupt;
    logic [2:0]  iAddress;
    wire  [31:0] bData;
    logic [7:0]  iBusMISO, oBusMOSI;
    logic        oBusClock, oInterrupt;
    logic [3:0]  oBusSelect;

    logic        drv_en;
    logic [31:0] drv_data;
    logic [7:0]  miso_key;
    logic        mon_on;

    int n_tests = 0;
    int n_fail  = 0;

    assign bData    = drv_en ? drv_data : 32'bz;
    assign iBusMISO = oBusMOSI ^ miso_key;

    always #5 iClock = ~iClock;

    sysx_master_v2 #(.BUS_W(8), .FIFO_DEPTH(16), .CHANNELS(4)) dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iWrite(iWrite),
        .iAddress(iAddress), .bData(bData), .iBusMISO(iBusMISO), .oBusMOSI(oBusMOSI),
        .oBusClock(oBusClock), .oBusSelect(oBusSelect),
        .iBusInterrupt(iBusInterrupt), .oInterrupt(oInterrupt)
    );

    typedef struct { logic [31:0] exp; string nm; } rd_t;
    typedef struct { logic [7:0] mosi; logic [3:0] sel; int width; } bus_t;
    typedef struct { logic [3:0] sel; int len; } sel_t;

    rd_t  exp_rd[$];
    bus_t exp_bus[$];
    sel_t exp_sel[$];

    // reference model
    bit [7:0] tx_q[$];
    bit [7:0] rx_q[$];
    logic [3:0] m_div;
    logic [2:0] m_chan;
    logic m_ierx, m_iebus, m_iedone, m_txovf, m_rxovf, m_done;
    int   m_wait;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {25'b0, iBusInterrupt, m_done, m_rxovf, m_txovf,
                rx_q.size() == 0, tx_q.size() == 16, 1'b0};
    endfunction

    function automatic logic [31:0] m_config();
        return {21'b0, m_iedone, m_iebus, m_ierx, 1'b0, m_chan, m_div};
    endfunction

    task automatic model_reset();
        tx_q.delete(); rx_q.delete();
        m_div = 0; m_chan = 0; m_ierx = 0; m_iebus = 0; m_iedone = 0;
        m_txovf = 0; m_rxovf = 0; m_done = 0;
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        iEnable = 1; iWrite = 1; iAddress = a; drv_en = 1; drv_data = d;
        @(negedge iClock);
        iEnable = 0; iWrite = 0; drv_en = 0;
    endtask

    task automatic reg_read(input logic [2:0] a, input logic [31:0] e, input string nm);
        rd_t r;
        r.exp = e; r.nm = nm;
        exp_rd.push_back(r);
        iEnable = 1; iWrite = 0; iAddress = a;
        @(negedge iClock);
        iEnable = 0;
    endtask

    task automatic tx_push(input logic [7:0] b);
        reg_write(3'd2, {24'b0, b});
        if (tx_q.size() < 16) tx_q.push_back(b);
        else m_txovf = 1;
    endtask

    task automatic rx_read(input string nm);
        logic [31:0] e;
        e = (rx_q.size() > 0) ? {24'b0, rx_q.pop_front()} : 32'h0;
        reg_read(3'd3, e, nm);
    endtask

    task automatic drain();
        while (rx_q.size() > 0) rx_read("rx_drain");
    endtask

    // Whole queued burst goes out under one select: (1 + 5*n) states of DIV+1 clocks.
    task automatic launch();
        int n = tx_q.size();
        int per = int'(m_div) + 1;
        logic [3:0] sel = (m_chan < 4) ? 4'(1 << m_chan) : 4'b0;
        bus_t b;
        foreach (tx_q[i]) begin
            b.mosi = tx_q[i]; b.sel = sel; b.width = 2 * per;
            exp_bus.push_back(b);
            if (rx_q.size() < 16) rx_q.push_back(tx_q[i] ^ miso_key);
            else m_rxovf = 1;
        end
        if (m_chan < 4) begin
            sel_t s;
            s.sel = sel; s.len = (1 + 5 * n) * per;
            exp_sel.push_back(s);
        end
        m_wait = (1 + 5 * n) * per + 4;
        tx_q.delete();
        m_done = 1;
    endtask

    task automatic cfg(input logic [3:0] dv, input logic [2:0] ch, input logic st,
                       input logic ierx, input logic iebus, input logic iedone, input logic busy);
        reg_write(3'd0, {21'b0, iedone, iebus, ierx, st, ch, dv});
        if (!busy) begin m_div = dv; m_chan = ch; end
        m_ierx = ierx; m_iebus = iebus; m_iedone = iedone;
        m_txovf = 0; m_rxovf = 0;
        // a write during a transfer clears done, but the transfer re-sets it at its end
        if (!busy) m_done = 0;
        if (st) launch();
    endtask

    // register read monitor
    always @(negedge iClock) begin
        #2;
        if (iEnable && !iWrite) begin
            if (exp_rd.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_unexpected: got %h expected no read", bData);
            end else begin
                rd_t r;
                r = exp_rd.pop_front();
                chk(r.nm, bData, r.exp);
            end
        end
    end

    // bus-side monitor
    logic       clk_prev = 1'b0;
    logic [3:0] sel_prev = 4'b0;
    int hi_cnt = 0, hi_exp = 0, sel_cnt = 0, sel_len = 0;
    always @(negedge iClock) begin
        #1;
        if (mon_on) begin
            if (oBusClock && !clk_prev) begin
                if (exp_bus.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL bus_unexpected: got mosi %h expected no transfer", oBusMOSI);
                end else begin
                    bus_t b;
                    b = exp_bus.pop_front();
                    chk("bus_mosi", {24'b0, oBusMOSI}, {24'b0, b.mosi});
                    chk("bus_sel", {28'b0, oBusSelect}, {28'b0, b.sel});
                    hi_exp = b.width;
                end
                hi_cnt = 1;
            end else if (oBusClock) begin
                hi_cnt++;
            end else if (clk_prev) begin
                chk("bus_clk_width", hi_cnt, hi_exp);
            end
            if (|oBusSelect && sel_prev == 4'b0) begin
                if (exp_sel.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sel_unexpected: got %b expected no select", oBusSelect);
                end else begin
                    sel_t s;
                    s = exp_sel.pop_front();
                    chk("sel_value", {28'b0, oBusSelect}, {28'b0, s.sel});
                    sel_len = s.len;
                end
                sel_cnt = 1;
            end else if (|oBusSelect) begin
                sel_cnt++;
            end else if (|sel_prev) begin
                chk("sel_width", sel_cnt, sel_len);
            end
        end
        clk_prev = oBusClock;
        sel_prev = oBusSelect;
    end

    initial begin
        iReset = 1; iEnable = 0; iWrite = 0; iAddress = 0; iBusInterrupt = 0;
        drv_en = 0; drv_data = 0; miso_key = 0; mon_on = 1;
        model_reset();
        repeat (3) @(negedge iClock);
        chk("rst_sel", {28'b0, oBusSelect}, 0);
        chk("rst_clk", {31'b0, oBusClock}, 0);
        chk("rst_mosi", {24'b0, oBusMOSI}, 0);
        iReset = 0;
        @(negedge iClock);
        chk("rst_irq", {31'b0, oInterrupt}, 0);
        reg_read(3'd1, m_status(), "rst_status");
        reg_read(3'd0, m_config(), "rst_config");
        reg_read(3'd4, 0, "rst_txcount");
        reg_read(3'd5, 0, "rst_rxcount");
        reg_read(3'd6, 32'h0BADC0DE, "bad_reg6");
        reg_read(3'd7, 32'h0BADC0DE, "bad_reg7");

        // single byte, DIV=0, CHAN=1
        miso_key = 8'hA5 ^ 8'h3C;
        cfg(4'd0, 3'd1, 0, 0, 0, 0, 0);
        tx_push(8'hA5);
        cfg(4'd0, 3'd1, 1, 0, 0, 0, 0);
        repeat (m_wait) @(negedge iClock);
        rx_read("rxdata_3c");
        reg_read(3'd1, m_status(), "status_done");

        // read RX while empty
        rx_read("rx_empty_read");
        reg_read(3'd5, 0, "rxcount_empty");

        // TX overflow then drain the full FIFO over the bus
        cfg(4'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) tx_push(8'($urandom));
        reg_read(3'd4, 16, "txcount_full");
        reg_read(3'd1, m_status(), "status_txovf");
        miso_key = 8'($urandom);
        cfg(m_div, m_chan, 1, 0, 0, 0, 0);
        repeat (m_wait) @(negedge iClock);
        reg_read(3'd5, 16, "rxcount_full");
        reg_read(3'd1, m_status(), "status_rxfull");
        for (int i = 0; i < 11; i++) rx_read("rx_partial");

        // RX push and pop in the same cycle at count 5
        tx_push(8'h69);
        cfg(4'd0, 3'd1, 1, 0, 0, 0, 0);
        repeat (5) @(negedge iClock);
        reg_read(3'd5, 5, "rxcount_before");
        rx_read("rx_simul_pop");
        reg_read(3'd5, 5, "rxcount_simul");
        repeat (4) @(negedge iClock);
        drain();

        // three bytes at DIV=2, plus a CONFIG write while busy
        miso_key = 8'($urandom);
        cfg(4'd2, 3'($urandom_range(3, 0)), 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tx_push(8'($urandom));
        cfg(4'd2, m_chan, 1, 0, 0, 0, 0);
        repeat (4) @(negedge iClock);
        cfg(4'd5, 3'd3, 0, 0, 0, 0, 1);
        reg_read(3'd0, m_config(), "config_busy_hold");
        repeat (m_wait) @(negedge iClock);
        drain();
        reg_read(3'd1, m_status(), "status_div2");

        // randomized rounds, including out-of-range channels
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(5, 1);
            miso_key = 8'($urandom);
            cfg(4'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 0, 0, 0, 0, 0);
            for (int i = 0; i < n; i++) tx_push(8'($urandom));
            reg_read(3'd4, n, "txcount_rand");
            cfg(m_div, m_chan, 1, 0, 0, 0, 0);
            repeat (m_wait) @(negedge iClock);
            reg_read(3'd5, rx_q.size(), "rxcount_rand");
            drain();
            reg_read(3'd1, m_status(), "status_rand");
        end

        // interrupts
        cfg(4'd0, 3'd1, 0, 0, 1, 0, 0);
        chk("irq_idle", {31'b0, oInterrupt}, 0);
        iBusInterrupt = 1;
        reg_read(3'd1, m_status(), "status_busirq");
        chk("irq_bus_on", {31'b0, oInterrupt}, 1);
        iBusInterrupt = 0;
        @(negedge iClock);
        chk("irq_bus_off", {31'b0, oInterrupt}, 0);
        cfg(4'd0, 3'd1, 0, 0, 0, 0, 0);
        iBusInterrupt = 1;
        @(negedge iClock);
        chk("irq_bus_masked", {31'b0, oInterrupt}, 0);
        iBusInterrupt = 0;
        @(negedge iClock);
        tx_push(8'h5A);
        cfg(4'd0, 3'd1, 1, 0, 0, 1, 0);
        repeat (m_wait) @(negedge iClock);
        chk("irq_done", {31'b0, oInterrupt}, 1);
        cfg(4'd0, 3'd1, 0, 1, 0, 0, 0);
        @(negedge iClock);
        chk("irq_rx", {31'b0, oInterrupt}, 1);
        drain();
        @(negedge iClock);
        chk("irq_rx_empty", {31'b0, oInterrupt}, 0);

        // reset in the middle of a byte
        mon_on = 0;
        reg_write(3'd0, {21'b0, 1'b1, 2'b0, 1'b0, 3'd2, 4'd3});
        reg_write(3'd2, 32'hC3);
        reg_write(3'd2, 32'h7E);
        reg_write(3'd0, {21'b0, 1'b1, 2'b0, 1'b1, 3'd2, 4'd3});
        for (int i = 0; i < 200 && !oBusClock; i++) @(negedge iClock);
        chk("rst_wait_clk", {31'b0, oBusClock}, 1);
        chk("rst_mosi_before", {24'b0, oBusMOSI}, 32'hC3);
        #1 iReset = 1;
        #1;
        chk("midrst_sel", {28'b0, oBusSelect}, 0);
        chk("midrst_clk", {31'b0, oBusClock}, 0);
        chk("midrst_mosi", {24'b0, oBusMOSI}, 0);
        chk("midrst_irq", {31'b0, oInterrupt}, 0);
        @(negedge iClock);
        iReset = 0;
        exp_bus.delete();
        exp_sel.delete();
        model_reset();
        @(negedge iClock);
        mon_on = 1;
        reg_read(3'd4, 0, "midrst_txcount");
        reg_read(3'd5, 0, "midrst_rxcount");
        reg_read(3'd1, m_status(), "midrst_status");
        reg_read(3'd0, 0, "midrst_config");
        repeat (4) @(negedge iClock);
        chk("midrst_sel_after", {28'b0, oBusSelect}, 0);

        repeat (2) @(negedge iClock);
        chk("exp_rd_left", exp_rd.size(), 0);
        chk("exp_bus_left", exp_bus.size(), 0);
        chk("exp_sel_left", exp_sel.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
